// File: rtl/bin_to_ascii_seq_if.sv
// Handshake and character-read bundle for bin_to_ascii_seq.
// The requester drives the operand, the conversion options and the column
// select; the converter returns its status flags and the selected character.
interface bin_to_ascii_seq_if #(
    parameter int WIDTH = 16,
    parameter int COL_W = 3
);
    logic             start;
    logic [WIDTH-1:0] value;
    logic             signed_mode;
    logic             pad_zero;
    logic [COL_W-1:0] col;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [7:0]       out;

    modport master (
        output start, value, signed_mode, pad_zero, col,
        input  busy, done, ovf, out
    );

    modport slave (
        input  start, value, signed_mode, pad_zero, col,
        output busy, done, ovf, out
    );
endinterface

// File: rtl/bin_to_ascii_seq.sv
// Sequential binary-to-ASCII decimal converter.
// A request latches the operand magnitude and options.  A double-dabble pass
// (one bit per cycle) builds the BCD image, then a single formatting cycle
// rewrites the whole character buffer at once.  The buffer keeps the previous
// result visible until that formatting cycle, so readers never observe a
// half-built number.
module bin_to_ascii_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 6,
    parameter int COL_W  = 3
) (
    input logic              clk,
    input logic              rst,
    bin_to_ascii_seq_if.slave bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int N_W   = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FORMAT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;

    logic [WIDTH-1:0] mag_r;
    logic             neg_r;
    logic             pad_r;
    logic [BCD_W-1:0] bcd_r;
    logic             bcd_ovf_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             ovf_r;
    logic [7:0]       char_r [DIGITS];

    logic [WIDTH-1:0] abs_s;
    logic [BCD_W-1:0] adj_s;
    logic [N_W-1:0]   n_s;
    logic             fmt_ovf_s;
    logic [7:0]       fmt_s [DIGITS];
    logic [7:0]       out_s;

    // Magnitude of the incoming operand; negation of the most negative value
    // wraps back to itself, which is the correct unsigned magnitude.
    always_comb begin
        abs_s = bus.value;
        if (bus.signed_mode && bus.value[WIDTH-1]) begin
            abs_s = ~bus.value + WIDTH'(1);
        end else begin
            abs_s = bus.value;
        end
    end

    // Double-dabble correction: every BCD digit of five or more gets plus three
    // so that the following left shift carries correctly into the next digit.
    always_comb begin
        adj_s = bcd_r;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_r[4*d +: 4] >= 4'd5) begin
                adj_s[4*d +: 4] = bcd_r[4*d +: 4] + 4'd3;
            end else begin
                adj_s[4*d +: 4] = bcd_r[4*d +: 4];
            end
        end
    end

    // Next-state logic of the conversion sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    state_s = ST_FORMAT;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_FORMAT: state_s = ST_DONE;
            ST_DONE:   state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Character image of the finished BCD value: digit count, sign placement,
    // fill style and the overflow replacement pattern.
    always_comb begin
        n_s = N_W'(1);
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_r[4*d +: 4] != 4'd0) begin
                n_s = N_W'(d + 1);
            end else begin
                n_s = n_s;
            end
        end

        // A minus sign needs one spare column beyond the digits.
        fmt_ovf_s = bcd_ovf_r || (neg_r && (n_s == N_W'(DIGITS)));

        for (int c = 0; c < DIGITS; c++) begin
            fmt_s[c] = 8'h20;
            if (fmt_ovf_s) begin
                fmt_s[c] = 8'h23;
            end else if (N_W'(c) < n_s) begin
                fmt_s[c] = 8'h30 + {4'h0, bcd_r[4*c +: 4]};
            end else if (pad_r) begin
                if (neg_r && (c == DIGITS - 1)) begin
                    fmt_s[c] = 8'h2D;
                end else begin
                    fmt_s[c] = 8'h30;
                end
            end else begin
                if (neg_r && (N_W'(c) == n_s)) begin
                    fmt_s[c] = 8'h2D;
                end else begin
                    fmt_s[c] = 8'h20;
                end
            end
        end
    end

    // Column read port; columns beyond the buffer read as space.
    always_comb begin
        out_s = 8'h20;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.col == COL_W'(i)) begin
                out_s = char_r[i];
            end else begin
                out_s = out_s;
            end
        end
    end

    // Sequencer state and registered status flags derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_SHIFT) || (state_s == ST_FORMAT);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Operand capture and the double-dabble shift engine.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_r     <= '0;
            neg_r     <= 1'b0;
            pad_r     <= 1'b0;
            bcd_r     <= '0;
            bcd_ovf_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        mag_r     <= abs_s;
                        neg_r     <= bus.signed_mode & bus.value[WIDTH-1];
                        pad_r     <= bus.pad_zero;
                        bcd_r     <= '0;
                        bcd_ovf_r <= 1'b0;
                        cnt_r     <= '0;
                    end
                end
                ST_SHIFT: begin
                    bcd_r     <= {adj_s[BCD_W-2:0], mag_r[WIDTH-1]};
                    bcd_ovf_r <= bcd_ovf_r | adj_s[BCD_W-1];
                    mag_r     <= {mag_r[WIDTH-2:0], 1'b0};
                    cnt_r     <= cnt_r + CNT_W'(1);
                end
                ST_FORMAT: begin
                    cnt_r <= '0;
                end
                ST_DONE: begin
                    cnt_r <= '0;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    // Result buffer and overflow flag; both change only in the format cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
            for (int c = 0; c < DIGITS; c++) begin
                char_r[c] <= 8'h20;
            end
        end else begin
            if (state_r == ST_FORMAT) begin
                ovf_r <= fmt_ovf_s;
                for (int c = 0; c < DIGITS; c++) begin
                    char_r[c] <= fmt_s[c];
                end
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.ovf  = ovf_r;
    assign bus.out  = out_s;

endmodule

// File: tb/tb_bin_to_ascii_seq.sv
// Directed bench for bin_to_ascii_seq: a six-column and a four-column
// instance run the same request stream in lockstep.
`timescale 1ns/1ps
module tb_bin_to_ascii_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        sm = 1'b0;
    logic        pz = 1'b0;
    logic [2:0]  col = 3'd0;

    int checks = 0;
    int errors = 0;

    always #50 clk = ~clk;

    bin_to_ascii_seq_if #(.WIDTH(16), .COL_W(3)) if6 ();
    bin_to_ascii_seq_if #(.WIDTH(16), .COL_W(3)) if4 ();

    assign if6.start       = start;
    assign if6.value       = value;
    assign if6.signed_mode = sm;
    assign if6.pad_zero    = pz;
    assign if6.col         = col;
    assign if4.start       = start;
    assign if4.value       = value;
    assign if4.signed_mode = sm;
    assign if4.pad_zero    = pz;
    assign if4.col         = col;

    bin_to_ascii_seq #(.WIDTH(16), .DIGITS(6), .COL_W(3)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (if6)
    );

    bin_to_ascii_seq #(.WIDTH(16), .DIGITS(4), .COL_W(3)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // exp packs columns as {col5, col4, ..., col0}
    task automatic check_row6(input string tag, input logic [47:0] exp);
        for (int c = 0; c < 6; c++) begin
            col = 3'(c);
            #1;
            check($sformatf("%s c6_%0d", tag, c), {24'h0, if6.out}, {24'h0, exp[8*c +: 8]});
        end
    endtask

    task automatic check_row4(input string tag, input logic [31:0] exp);
        for (int c = 0; c < 4; c++) begin
            col = 3'(c);
            #1;
            check($sformatf("%s c4_%0d", tag, c), {24'h0, if4.out}, {24'h0, exp[8*c +: 8]});
        end
    endtask

    // Issue one request, scramble the operand afterwards and wait for done.
    task automatic run(input string tag, input logic [15:0] v, input logic s, input logic p);
        int cyc;
        @(negedge clk);
        value = v;
        sm    = s;
        pz    = p;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check({tag, " busy"}, {31'h0, if6.busy}, 32'd1);
        value = ~v;
        sm    = ~s;
        pz    = ~p;
        while (!if6.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, cyc, 32'd18);
        check({tag, " busy_at_done"}, {31'h0, if6.busy}, 32'd0);
        check({tag, " done4"}, {31'h0, if4.done}, 32'd1);
    endtask

    initial begin
        int ndone;

        // Reset, with a start held alongside it that must be ignored
        repeat (2) @(negedge clk);
        start = 1'b1;
        value = 16'd55;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst busy", {31'h0, if6.busy}, 32'd0);
        check("rst done", {31'h0, if6.done}, 32'd0);
        check("rst ovf", {31'h0, if6.ovf}, 32'd0);
        check_row6("rst", 48'h20_20_20_20_20_20);
        col = 3'd6;
        #1;
        check("col6 space", {24'h0, if6.out}, 32'h20);
        col = 3'd7;
        #1;
        check("col7 space", {24'h0, if6.out}, 32'h20);

        run("u1234", 16'd1234, 1'b0, 1'b0);
        check("u1234 ovf", {31'h0, if6.ovf}, 32'd0);
        check_row6("u1234", 48'h20_20_31_32_33_34);

        run("sFFFF", 16'hFFFF, 1'b1, 1'b0);
        check_row6("sFFFF", 48'h20_20_20_20_2D_31);

        run("s8000", 16'h8000, 1'b1, 1'b0);
        check("s8000 ovf", {31'h0, if6.ovf}, 32'd0);
        check_row6("s8000", 48'h2D_33_32_37_36_38);

        run("u42p", 16'd42, 1'b0, 1'b1);
        check_row6("u42p", 48'h30_30_30_30_34_32);

        run("sm42p", 16'hFFD6, 1'b1, 1'b1);
        check_row6("sm42p", 48'h2D_30_30_30_34_32);

        run("u0", 16'd0, 1'b0, 1'b0);
        check_row6("u0", 48'h20_20_20_20_20_30);

        run("u12345", 16'd12345, 1'b0, 1'b0);
        check("u12345 ovf4", {31'h0, if4.ovf}, 32'd1);
        check("u12345 ovf6", {31'h0, if6.ovf}, 32'd0);
        check_row4("u12345", 32'h23_23_23_23);
        check_row6("u12345", 48'h20_31_32_33_34_35);

        run("u7", 16'd7, 1'b0, 1'b0);
        check("u7 ovf4", {31'h0, if4.ovf}, 32'd0);
        check_row4("u7", 32'h20_20_20_37);

        run("sm1234", 16'hFB2E, 1'b1, 1'b0);
        check("sm1234 ovf4", {31'h0, if4.ovf}, 32'd1);
        check("sm1234 ovf6", {31'h0, if6.ovf}, 32'd0);
        check_row4("sm1234", 32'h23_23_23_23);
        check_row6("sm1234", 48'h20_2D_31_32_33_34);

        // Second start during SHIFT is dropped; buffer holds old result meanwhile
        @(negedge clk);
        value = 16'd5678;
        sm    = 1'b0;
        pz    = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        value = 16'd999;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid busy", {31'h0, if6.busy}, 32'd1);
        check_row6("mid hold", 48'h20_2D_31_32_33_34);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (if6.done) ndone++;
        end
        check("mid done count", ndone, 32'd1);
        check_row6("mid result", 48'h20_20_35_36_37_38);

        // Reset in the fifth SHIFT cycle aborts the conversion silently
        @(negedge clk);
        value = 16'd4321;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", {31'h0, if6.busy}, 32'd0);
        check("abort ovf", {31'h0, if6.ovf}, 32'd0);
        check_row6("abort", 48'h20_20_20_20_20_20);
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (if6.done) ndone++;
        end
        check("abort done count", ndone, 32'd0);

        run("after", 16'd7, 1'b0, 1'b1);
        check_row6("after", 48'h30_30_30_30_30_37);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
